a23_mem_arbiter: RTL and testbench



---
 rtl/a23_mem_arbiter_pkg.sv | 32 +++
 rtl/a23_mem_arbiter_if.sv | 38 +++
 rtl/a23_mem_arbiter_access_check.sv | 22 ++
 rtl/a23_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_a23_mem_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/a23_mem_arbiter_pkg.sv
// Shared types and constants for the a23 memory arbiter: FSM states, grant ids,
// memory-map regions and the byte-enable patterns a write may legally use.
package a23_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [7:0] REG_CODE  = 8'h00;
  localparam logic [7:0] REG_G     = 8'h01;
  localparam logic [7:0] REG_E     = 8'h02;
  localparam logic [7:0] REG_OUT   = 8'h03;
  localparam logic [7:0] REG_STACK = 8'h04;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;

  // Whole-word or single-byte stores only; half-words and gaps are rejected.
  function automatic logic be_is_legal(logic [3:0] be);
    return (be == BE_WORD) || (be == BE_B0) || (be == BE_B1) ||
           (be == BE_B2) || (be == BE_B3);
  endfunction

endpackage

// File: rtl/a23_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the a23 memory arbiter.
// slave is the arbiter's view; master is the core/memory side.
interface a23_mem_arbiter_if;
  logic        i_i_req;
  logic [31:0] i_i_address;
  logic        o_i_ack;
  logic [31:0] o_i_rdata;
  logic        o_i_err;

  logic        i_d_req;
  logic [31:0] i_d_address;
  logic [31:0] i_d_write;
  logic        i_d_write_en;
  logic [3:0]  i_d_byte_enable;
  logic        o_d_ack;
  logic [31:0] o_d_rdata;
  logic        o_d_err;

  logic [31:0] o_m_address;
  logic [31:0] o_m_write;
  logic        o_m_write_en;
  logic [3:0]  o_m_byte_enable;
  logic [31:0] i_m_read;

  modport slave (
    input  i_i_req, i_i_address, i_d_req, i_d_address, i_d_write, i_d_write_en,
    input  i_d_byte_enable, i_m_read,
    output o_i_ack, o_i_rdata, o_i_err, o_d_ack, o_d_rdata, o_d_err,
    output o_m_address, o_m_write, o_m_write_en, o_m_byte_enable
  );

  modport master (
    output i_i_req, i_i_address, i_d_req, i_d_address, i_d_write, i_d_write_en,
    output i_d_byte_enable, i_m_read,
    input  o_i_ack, o_i_rdata, o_i_err, o_d_ack, o_d_rdata, o_d_err,
    input  o_m_address, o_m_write, o_m_write_en, o_m_byte_enable
  );
endinterface

// File: rtl/a23_mem_arbiter_access_check.sv
// Memory-map access policy: any mapped region may be read; only code, output
// and stack may be written, and only as a full word or a single byte.
module a23_mem_access_check
  import a23_mem_arb_pkg::*;
(
  input  logic [7:0] i_region,
  input  logic       i_write_en,
  input  logic [3:0] i_byte_enable,
  output logic       o_legal
);

  always_comb begin
    o_legal = 1'b0;
    if (i_write_en) begin
      o_legal = ((i_region == REG_CODE) || (i_region == REG_OUT) || (i_region == REG_STACK)) &&
                be_is_legal(i_byte_enable);
    end else begin
      o_legal = (i_region <= REG_STACK);
    end
  end

endmodule

// File: rtl/a23_mem_arbiter.sv
// Single-port memory arbiter for the a23 core: fetch vs data, IDLE/SERVE/RESP
// sequencing, registered read data and bounded fetch starvation.
module a23_mem_arbiter
  import a23_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  a23_mem_arbiter_if.slave  bus,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  arb_state_t       state_q, state_d;
  logic             gnt_q, gnt_sel, grant;
  logic [31:0]      addr_q, wdata_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      i_rdata_q, d_rdata_q;
  logic             i_err_q, d_err_q;
  logic             legal;

  a23_mem_access_check u_check (
    .i_region      (addr_q[31:24]),
    .i_write_en    (we_q),
    .i_byte_enable (be_q),
    .o_legal       (legal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    gnt_sel = gnt_q;
    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has already lost MAX_WAIT times in a row.
        if (bus.i_d_req && (!bus.i_i_req || (cnt_q != MAX_CNT))) begin
          grant   = 1'b1;
          gnt_sel = GNT_D;
          state_d = SERVE;
          if (bus.i_i_req) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.i_i_req) begin
          grant   = 1'b1;
          gnt_sel = GNT_I;
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        gnt_q <= gnt_sel;
        if (gnt_sel == GNT_D) begin
          addr_q  <= bus.i_d_address;
          wdata_q <= bus.i_d_write;
          we_q    <= bus.i_d_write_en;
          be_q    <= bus.i_d_byte_enable;
        end else begin
          addr_q  <= bus.i_i_address;
          wdata_q <= '0;
          we_q    <= 1'b0;
          be_q    <= BE_WORD;
        end
      end
      if (state_q == SERVE) begin
        if (gnt_q == GNT_D) begin
          d_rdata_q <= legal ? bus.i_m_read : 32'h0;
          d_err_q   <= ~legal;
        end else begin
          i_rdata_q <= legal ? bus.i_m_read : 32'h0;
          i_err_q   <= ~legal;
        end
      end
    end
  end

  // Memory port is only driven while serving, so no stray writes elsewhere.
  always_comb begin
    bus.o_m_address     = '0;
    bus.o_m_write       = '0;
    bus.o_m_write_en    = 1'b0;
    bus.o_m_byte_enable = '0;
    if (state_q == SERVE) begin
      bus.o_m_address     = addr_q & 32'hFFFF_FFFC;
      bus.o_m_write       = wdata_q;
      bus.o_m_write_en    = we_q & legal;
      bus.o_m_byte_enable = be_q;
    end
  end

  assign bus.o_i_ack   = (state_q == RESP) && (gnt_q == GNT_I);
  assign bus.o_d_ack   = (state_q == RESP) && (gnt_q == GNT_D);
  assign bus.o_i_rdata = i_rdata_q;
  assign bus.o_i_err   = i_err_q;
  assign bus.o_d_rdata = d_rdata_q;
  assign bus.o_d_err   = d_err_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_a23_mem_arbiter.sv
// Self-checking bench for a23_mem_arbiter: a simple memory on the m-port and a
// map-level reference model of expected data, errors, writes and grant order.
module tb_a23_mem_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam logic [31:0] G_INIT   = 32'h6A09_E667;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic init_mem;
  always #5 clk = ~clk;

  a23_mem_arbiter_if bus ();

  a23_mem_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy)
  );

  // Memory stand-in: 8 words per region, indexed by region[2:0] and word[2:0].
  logic [31:0] mem [64];
  logic [5:0]  m_idx;
  int unsigned wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  assign m_idx = {bus.o_m_address[26:24], bus.o_m_address[4:2]};
  assign bus.i_m_read = mem[m_idx];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[8] <= G_INIT;
    end else if (bus.o_m_write_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_m_byte_enable[b]) mem[m_idx][8*b +: 8] <= bus.o_m_write[8*b +: 8];
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.o_m_address;
    end
  end

  // Reference model: word-addressed map contents, unwritten words read as 0.
  logic [31:0] ref_mem [logic [31:0]];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] key;
    key = addr & 32'hFFFF_FFFC;
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic access(input string tag, input bit is_d, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic we, input logic [3:0] be);
    logic [7:0]  region;
    logic        legal;
    logic [31:0] exp_rd, key, obs_rd;
    logic        obs_err;
    int unsigned wr0;
    int          n;
    bit          got;
    region = addr[31:24];
    if (is_d && we)
      legal = (region inside {8'h00, 8'h03, 8'h04}) &&
              (be inside {4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000});
    else
      legal = (region <= 8'h04);
    exp_rd = (legal && !(is_d && we)) ? model_read(addr) : 32'h0;
    wr0 = wr_cnt;
    @(negedge clk);
    if (is_d) begin
      bus.i_d_address = addr; bus.i_d_write = wdata;
      bus.i_d_write_en = we; bus.i_d_byte_enable = be; bus.i_d_req = 1'b1;
    end else begin
      bus.i_i_address = addr; bus.i_i_req = 1'b1;
    end
    @(posedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clk); n++; #1;
      got = is_d ? bus.o_d_ack : bus.o_i_ack;
    end
    obs_rd  = is_d ? bus.o_d_rdata : bus.o_i_rdata;
    obs_err = is_d ? bus.o_d_err : bus.o_i_err;
    bus.i_d_req = 1'b0;
    bus.i_i_req = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd1);
    check({tag, " err"}, {31'd0, obs_err}, {31'd0, ~legal});
    if (!(is_d && we)) check({tag, " rdata"}, obs_rd, exp_rd);
    if (is_d && we && legal) begin
      key = addr & 32'hFFFF_FFFC;
      ref_mem[key] = model_read(addr);
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[key][8*b +: 8] = wdata[8*b +: 8];
    end
    @(posedge clk); #1;
    check({tag, " ack pulse"}, {30'd0, bus.o_i_ack, bus.o_d_ack}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " writes"}, wr_cnt - wr0, (is_d && we && legal) ? 32'd1 : 32'd0);
    if (is_d && we && legal) check({tag, " waddr"}, wr_addr, addr & 32'hFFFF_FFFC);
  endtask

  logic [3:0] be_tab [9];
  initial begin
    int          d_since, n;
    bit          got, exp_d;
    int unsigned wr0, acks;
    logic [7:0]  region;
    logic [31:0] addr;
    bit          is_d, we;

    be_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h6, 4'h0};
    ref_mem[32'h0100_0000] = G_INIT;
    bus.i_i_req = 0; bus.i_i_address = '0;
    bus.i_d_req = 0; bus.i_d_address = '0; bus.i_d_write = '0;
    bus.i_d_write_en = 0; bus.i_d_byte_enable = '0;
    rst = 1'b1; init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {bus.o_i_ack, bus.o_i_err, bus.o_d_ack, bus.o_d_err, busy,
                            bus.o_m_write_en, bus.o_m_byte_enable, 24'd0}, 32'd0);
    check("reset rdata", bus.o_i_rdata | bus.o_d_rdata | bus.o_m_address | bus.o_m_write,
          32'd0);
    @(negedge clk); rst = 1'b0; init_mem = 1'b0;

    access("wr out", 1, 32'h0300_0004, 32'hDEAD_BEEF, 1, 4'hF);
    access("rd out", 1, 32'h0300_0004, 32'h0, 0, 4'hF);
    access("wr garbler", 1, 32'h0100_0000, 32'h1234_5678, 1, 4'hF);
    access("rd garbler", 1, 32'h0100_0000, 32'h0, 0, 4'hF);
    access("wr byte1", 1, 32'h0400_0000, 32'hABAB_ABAB, 1, 4'b0010);
    access("rd byte1", 1, 32'h0400_0000, 32'h0, 0, 4'hF);
    access("wr be0011", 1, 32'h0400_0000, 32'hFFFF_FFFF, 1, 4'b0011);
    access("rd be0011", 1, 32'h0400_0000, 32'h0, 0, 4'hF);
    access("fetch unmapped", 0, 32'h0500_0000, 32'h0, 0, 4'hF);
    access("fetch out", 0, 32'h0300_0006, 32'h0, 0, 4'hF);

    // Contention after a fresh reset: both ports keep requesting.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.i_i_address = 32'h0000_0004; bus.i_i_req = 1'b1;
    bus.i_d_address = 32'h0300_0004; bus.i_d_write_en = 1'b0;
    bus.i_d_byte_enable = 4'hF; bus.i_d_req = 1'b1;
    d_since = 0;
    for (int g = 0; g < 10; g++) begin
      n = 0; got = 1'b0;
      while (!got && n < 8) begin
        @(posedge clk); n++; #1;
        got = bus.o_d_ack | bus.o_i_ack;
      end
      exp_d = (d_since != int'(MAX_WAIT));
      d_since = exp_d ? d_since + 1 : 0;
      check($sformatf("grant %0d port", g), {31'd0, bus.o_d_ack}, {31'd0, exp_d});
      check($sformatf("grant %0d spacing", g), 32'(n), (g == 0) ? 32'd2 : 32'd3);
    end
    bus.i_i_req = 1'b0; bus.i_d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a legal write is in SERVE.
    wr0 = wr_cnt;
    @(negedge clk);
    bus.i_d_address = 32'h0400_0008; bus.i_d_write = 32'h1234_5678;
    bus.i_d_write_en = 1'b1; bus.i_d_byte_enable = 4'hF; bus.i_d_req = 1'b1;
    @(posedge clk); #1;
    check("midrst serve we", {31'd0, bus.o_m_write_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst outputs", {bus.o_i_ack, bus.o_d_ack, bus.o_d_err, busy,
                             bus.o_m_write_en, 27'd0}, 32'd0);
    check("midrst maddr", bus.o_m_address | bus.o_m_write | bus.o_d_rdata, 32'd0);
    bus.i_d_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.o_d_ack) acks++;
    end
    check("midrst no ack", acks, 32'd0);
    check("midrst no write", wr_cnt - wr0, 32'd0);
    access("midrst rd", 1, 32'h0400_0008, 32'h0, 0, 4'hF);

    for (int k = 0; k < 40; k++) begin
      is_d   = ($urandom_range(0, 3) != 0);
      we     = is_d && ($urandom_range(0, 1) == 1);
      region = 8'($urandom_range(0, 5));
      addr   = {region, 19'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access($sformatf("rand %0d", k), is_d, addr, $urandom, we, be_tab[$urandom_range(0, 8)]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
